// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Registered, back-pressured front end for the 64-bit combinational ALU.
// Requests enter over a valid/ready port and are held in an operand register
// (S1). That register drives the ALU directly. The ALU result and flags are
// then captured into a response register (S2). The block also keeps the
// architectural N/Z/V/C flag register used by branch logic, and a count of
// completed responses.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_a, req_b, req_op, req_setflags,
//                     req_tag carry the operation
//   flush             synchronous discard of everything in flight
//   alu_a, alu_b,     registered operands and control to the ALU
//   alu_cntrl
//   alu_result,       ALU result and flags, consumed while S1 advances
//   alu_negative, alu_zero, alu_overflow, alu_carry_out
//   rsp_valid/ready   response handshake; rsp_result, rsp_flags {N,Z,V,C},
//                     rsp_tag, rsp_err carry the completed operation
//   flags             architectural {N,Z,V,C}
//   op_count          number of completed response handshakes (wraps)
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, the payload stays stable
// until that transfer. Valid never depends combinationally on ready. Ready
// (req_ready here) may depend combinationally on the consumer's ready
// (rsp_ready) and on flush.
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic             req_setflags,
    input  logic [TAGW-1:0]  req_tag,

    input  logic             flush,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_err,

    output logic [3:0]       flags,
    output logic [31:0]      op_count
);

    // ALU control encodings.
    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ILL_1  = 3'b001;
    localparam logic [2:0] OP_ILL_7  = 3'b111;

    // ------------------------------------------------------------------
    // S1: operand register. alu_a / alu_b / alu_cntrl are the S1 storage
    // itself, so the ALU never sees a combinational path from req_*.
    // ------------------------------------------------------------------
    logic            s1_valid;
    logic            s1_setflags;
    logic [TAGW-1:0] s1_tag;
    logic            s1_illegal;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic       s2_free;
    logic       s1_adv;
    logic       req_fire;
    logic       rsp_fire;
    logic       s2_load;
    logic       flags_we;
    logic       req_illegal;
    logic [3:0] alu_flags;
    logic [WIDTH-1:0] s2_result_d;
    logic [3:0]       s2_flags_d;

    assign req_illegal = (req_op == OP_ILL_1) || (req_op == OP_ILL_7);

    assign s2_free   = !rsp_valid || rsp_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign req_ready = !flush && (!s1_valid || s1_adv);

    // req_ready already folds in flush, so an accepted request is never
    // one presented during a flush cycle.
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Flush has priority: nothing moves into S2 on a flush edge.
    assign s2_load   = s1_adv && !flush;
    assign flags_we  = s2_load && s1_setflags && !s1_illegal;

    assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

    // An illegal op gets a zero result and zero flags, whatever the ALU
    // produced for its forced pass-B control.
    assign s2_result_d = s1_illegal ? '0    : alu_result;
    assign s2_flags_d  = s1_illegal ? 4'h0  : alu_flags;

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_setflags <= 1'b0;
            s1_tag      <= '0;
            s1_illegal  <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cntrl   <= OP_PASS_B;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (req_fire) begin
            // Covers both an empty S1 and an S1 that drains into S2 on this
            // same edge; in either case the new operation takes its place.
            s1_valid    <= 1'b1;
            s1_setflags <= req_setflags;
            s1_tag      <= req_tag;
            s1_illegal  <= req_illegal;
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_cntrl   <= req_illegal ? OP_PASS_B : req_op;
        end else if (s1_adv) begin
            // Operands are left in place so the ALU inputs stay quiet while
            // S1 is empty.
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2 register (response)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'h0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (s2_load) begin
            // A handshake of the previous response and this load can share
            // an edge; the new response simply replaces the old one.
            rsp_valid  <= 1'b1;
            rsp_result <= s2_result_d;
            rsp_flags  <= s2_flags_d;
            rsp_tag    <= s1_tag;
            rsp_err    <= s1_illegal;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Architectural flags: loaded on the same edge as S2, with the same
    // value that goes into rsp_flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'h0;
        end else if (flags_we) begin
            flags <= alu_flags;
        end
    end

    // ------------------------------------------------------------------
    // Completed-response counter. Error responses count too. A flush edge
    // discards the response, so it is not counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 32'd0;
        end else if (rsp_fire && !flush) begin
            op_count <= op_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Directed bench for alu_issue. A behavioural ALU sits beside the DUT and
// closes the alu_* loop. Every expected response value is a hand-computed
// constant, pushed into a queue when the request is issued. A monitor pops
// the queue on each response handshake.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    localparam int WIDTH = 64;
    localparam int TAGW  = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic             req_setflags;
    logic [TAGW-1:0]  req_tag;
    logic             flush;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cntrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAGW-1:0]  rsp_tag;
    logic             rsp_err;
    logic [3:0]       flags;
    logic [31:0]      op_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected responses: {tag[3:0], err, flags[3:0], result[63:0]}
    logic [72:0] exp_q[$];
    logic [72:0] mon_e;

    alu_issue #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_setflags  (req_setflags),
        .req_tag       (req_tag),
        .flush         (flush),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cntrl     (alu_cntrl),
        .alu_result    (alu_result),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .flags         (flags),
        .op_count      (op_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural ALU ----------------
    logic [64:0] alu_sum;
    always_comb begin
        alu_sum       = 65'd0;
        alu_result    = '0;
        alu_overflow  = 1'b0;
        alu_carry_out = 1'b0;
        case (alu_cntrl)
            3'b000: alu_result = alu_b;
            3'b010: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result    = alu_sum[63:0];
                alu_carry_out = alu_sum[64];
                alu_overflow  = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b011: begin
                alu_sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result    = alu_sum[63:0];
                alu_carry_out = alu_sum[64];
                alu_overflow  = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b110: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_negative = alu_result[63];
        alu_zero     = (alu_result == '0);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected_valid", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_tag",    64'(rsp_tag),   64'(mon_e[72:69]));
                check("rsp_err",    64'(rsp_err),   64'(mon_e[68]));
                check("rsp_flags",  64'(rsp_flags), 64'(mon_e[67:64]));
                check("rsp_result", rsp_result,     mon_e[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         input logic sf, input logic [3:0] tag, input logic push,
                         input logic [63:0] exp_res, input logic [3:0] exp_flg,
                         input logic exp_err);
        int waited = 0;
        req_a        = a;
        req_b        = b;
        req_op       = op;
        req_setflags = sf;
        req_tag      = tag;
        req_valid    = 1'b1;
        if (push) exp_q.push_back({tag, exp_err, exp_flg, exp_res});
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("req_accept_timeout", 64'(waited < 50), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_timeout", 64'(cyc < 50), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    time t0;

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_a        = '0;
        req_b        = '0;
        req_op       = 3'b000;
        req_setflags = 1'b0;
        req_tag      = '0;
        flush        = 1'b0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst_rsp_result", rsp_result,      64'd0);
        check("rst_rsp_flags",  64'(rsp_flags),  64'd0);
        check("rst_rsp_tag",    64'(rsp_tag),    64'd0);
        check("rst_rsp_err",    64'(rsp_err),    64'd0);
        check("rst_alu_a",      alu_a,           64'd0);
        check("rst_alu_b",      alu_b,           64'd0);
        check("rst_alu_cntrl",  64'(alu_cntrl),  64'd0);
        check("rst_flags",      64'(flags),      64'd0);
        check("rst_op_count",   64'(op_count),   64'd0);
        check("rst_req_ready",  64'(req_ready),  64'd1);
        @(posedge clk);
        #1;

        // Add 5+3 with latency check
        issue(64'd5, 64'd3, 3'b010, 1'b1, 4'd1, 1'b1, 64'd8, 4'b0000, 1'b0);
        @(negedge clk);
        check("lat_rsp_valid_s1", 64'(rsp_valid), 64'd0);
        check("lat_alu_a",        alu_a,          64'd5);
        check("lat_alu_b",        alu_b,          64'd3);
        check("lat_alu_cntrl",    64'(alu_cntrl), 64'd2);
        @(negedge clk);
        check("lat_rsp_valid_s2", 64'(rsp_valid), 64'd1);
        check("lat_rsp_result",   rsp_result,     64'd8);
        drain();
        check("add_flags", 64'(flags), 64'd0);

        // Subtract 3-5: negative, borrow (C=0)
        issue(64'd3, 64'd5, 3'b011, 1'b1, 4'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
        drain();
        check("sub_neg_flags", 64'(flags), 64'h8);

        // Subtract 5-5: zero, no borrow (C=1)
        issue(64'd5, 64'd5, 3'b011, 1'b1, 4'd3, 1'b1, 64'd0, 4'b0101, 1'b0);
        drain();
        check("sub_zero_flags", 64'(flags), 64'h5);

        // Signed overflow without setflags: arch flags hold
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0, 4'd4, 1'b1,
              64'h8000_0000_0000_0000, 4'b1010, 1'b0);
        drain();
        check("ovf_flags_hold", 64'(flags), 64'h5);

        // Logic ops back-to-back at full rate
        t0 = $time;
        issue(64'hF0F0, 64'hFF00, 3'b100, 1'b0, 4'd5, 1'b1, 64'hF000, 4'b0000, 1'b0);
        issue(64'hF0F0, 64'hFF00, 3'b101, 1'b0, 4'd6, 1'b1, 64'hFFF0, 4'b0000, 1'b0);
        issue(64'hF0F0, 64'hFF00, 3'b110, 1'b0, 4'd7, 1'b1, 64'h0FF0, 4'b0000, 1'b0);
        issue(64'd123,  64'd0,    3'b000, 1'b0, 4'd8, 1'b1, 64'd0,    4'b0100, 1'b0);
        check("throughput_ns", 64'($time - t0), 64'd40);
        drain();
        check("op_count_8", 64'(op_count), 64'd8);

        // Back-pressure: tags 1,2 accepted, 3 stalls
        do_reset();
        rsp_ready = 1'b0;
        issue(64'd1, 64'd1, 3'b010, 1'b0, 4'd1, 1'b1, 64'd2, 4'b0000, 1'b0);
        issue(64'd2, 64'd2, 3'b010, 1'b0, 4'd2, 1'b1, 64'd4, 4'b0000, 1'b0);
        req_a        = 64'd3;
        req_b        = 64'd3;
        req_op       = 3'b010;
        req_setflags = 1'b0;
        req_tag      = 4'd3;
        req_valid    = 1'b1;
        exp_q.push_back({4'd3, 1'b0, 4'b0000, 64'd6});
        @(negedge clk);
        check("bp_req_ready",   64'(req_ready), 64'd0);
        check("bp_rsp_valid",   64'(rsp_valid), 64'd1);
        check("bp_rsp_tag",     64'(rsp_tag),   64'd1);
        repeat (3) @(negedge clk);
        check("bp_hold_tag",    64'(rsp_tag),   64'd1);
        check("bp_hold_result", rsp_result,     64'd2);
        check("bp_hold_ready",  64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();
        @(negedge clk);
        check("bp_op_count",  64'(op_count),  64'd3);
        check("bp_rsp_empty", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Illegal opcodes
        do_reset();
        issue(64'd5, 64'd5, 3'b011, 1'b1, 4'd9, 1'b1, 64'd0, 4'b0101, 1'b0);
        drain();
        issue(64'd5, 64'd3, 3'b111, 1'b1, 4'd10, 1'b1, 64'd0, 4'b0000, 1'b1);
        @(negedge clk);
        check("ill_alu_cntrl", 64'(alu_cntrl), 64'd0);
        check("ill_alu_a",     alu_a,          64'd5);
        drain();
        check("ill7_flags_hold", 64'(flags), 64'h5);
        issue(64'd9, 64'd9, 3'b001, 1'b1, 4'd11, 1'b1, 64'd0, 4'b0000, 1'b1);
        drain();
        check("ill1_flags_hold", 64'(flags),    64'h5);
        check("ill_op_count",    64'(op_count), 64'd3);

        // Flush with two in flight
        do_reset();
        rsp_ready = 1'b0;
        issue(64'd5, 64'd5, 3'b011, 1'b1, 4'd5, 1'b0, 64'd0, 4'b0000, 1'b0);
        issue(64'd3, 64'd5, 3'b011, 1'b1, 4'd6, 1'b0, 64'd0, 4'b0000, 1'b0);
        flush        = 1'b1;
        req_a        = 64'd1;
        req_b        = 64'd1;
        req_op       = 3'b010;
        req_setflags = 1'b1;
        req_tag      = 4'd7;
        req_valid    = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("flush_quiet",    64'(rsp_valid), 64'd0);
        check("flush_flags",    64'(flags),     64'h5);
        check("flush_op_count", 64'(op_count),  64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation
        do_reset();
        rsp_ready = 1'b0;
        issue(64'd5, 64'd5, 3'b011, 1'b1, 4'd12, 1'b0, 64'd0, 4'b0000, 1'b0);
        issue(64'd7, 64'd9, 3'b100, 1'b0, 4'd13, 1'b0, 64'd0, 4'b0000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid",  64'(rsp_valid), 64'd0);
        check("arst_rsp_result", rsp_result,     64'd0);
        check("arst_rsp_flags",  64'(rsp_flags), 64'd0);
        check("arst_rsp_tag",    64'(rsp_tag),   64'd0);
        check("arst_rsp_err",    64'(rsp_err),   64'd0);
        check("arst_alu_a",      alu_a,          64'd0);
        check("arst_alu_b",      alu_b,          64'd0);
        check("arst_alu_cntrl",  64'(alu_cntrl), 64'd0);
        check("arst_flags",      64'(flags),     64'd0);
        check("arst_op_count",   64'(op_count),  64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_quiet",       64'(rsp_valid), 64'd0);
        check("arst_op_count_end", 64'(op_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered, back-pressured front end for the 64-bit combinational `alu`; it drives that ALU's operand and control ports and consumes its result and flag outputs. It accepts operations over a valid/ready request port and launches them from an operand register into the ALU. It captures the result and N/Z/V/C flags into a response register and maintains the architectural flag register used by branch logic. The ALU instance sits beside this block in the datapath.

## Interface
- `WIDTH`, 64, datapath width; must equal the ALU width.
- `TAGW`, 4, width of the opaque request tag.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_a`, `req_b`  in  WIDTH  operands.
- `req_op`  in  3  ALU control code.
- `req_setflags`  in  1  update the flag register on completion.
- `req_tag`  in  TAGW  returned unchanged with the response.
- `flush`  in  1  synchronous discard of all in-flight operations.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_cntrl`  out  3  registered control to the ALU.
- `alu_result`  in  WIDTH  ALU result.
- `alu_negative`, `alu_zero`, `alu_overflow`, `alu_carry_out`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_flags`  out  4  {N,Z,V,C} of this operation.
- `rsp_tag`  out  TAGW  tag of this operation.
- `rsp_err`  out  1  illegal opcode.
- `flags`  out  4  architectural {N,Z,V,C}.
- `op_count`  out  32  completed response handshakes, wraps at 2^32.

## Operation
- Legal `req_op` codes:
  - 000 pass B
  - 010 add
  - 011 subtract (A−B)
  - 100 and
  - 101 or
  - 110 xor
- Codes 001 and 111 are illegal.
- Stage 1 (S1) is the operand register.
  - Holds `s1_valid`, A, B, op, setflags, tag, illegal bit.
  - Its registers drive `alu_a`, `alu_b` and `alu_cntrl` directly; there is no combinational path from `req_*` to `alu_*`.
  - An illegal op drives `alu_cntrl`=000.
- Stage 2 (S2) is the response register; it drives all `rsp_*` outputs.
- Advance rules:
  - `s2_free = !rsp_valid | rsp_ready`.
  - `s1_adv = s1_valid & s2_free`.
  - `req_ready = !flush & (!s1_valid | s1_adv)`.
- S2 capture on `s1_adv`:
  - `rsp_result` ← `alu_result`, `rsp_flags` ← {N,Z,V,C}, `rsp_tag` ← S1 tag, `rsp_err` ← 0.
  - If the S1 op is illegal: `rsp_result` ← 0, `rsp_flags` ← 0000, `rsp_err` ← 1.
- `flags` is written on `s1_adv` only when S1 setflags=1 and the op is legal, with the same value loaded into `rsp_flags`. Otherwise `flags` holds.
- `op_count` increments on every response handshake, including error responses.
- `flush`:
  - Next edge: `s1_valid` ← 0, `rsp_valid` ← 0.
  - A request presented in the flush cycle is not accepted.
  - `flags` and `op_count` are unchanged.
  - `flush` has priority over all advances.
- When S1 is empty, `alu_*` hold their last values.
- When S2 holds without a handshake, `rsp_*` are stable.

## Timing
- Reset (`rst_n`=0, asynchronous): every register clears.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_tag`=0, `rsp_err`=0.
  - `alu_a`=0, `alu_b`=0, `alu_cntrl`=000.
  - `flags`=0000, `op_count`=0.
  - `req_ready`=1 as soon as reset is released and `flush`=0.
  - Reset mid-operation drops all in-flight work with no response.
- Latency: a request accepted at edge n produces `rsp_valid`=1 after edge n+1, provided S2 was free at edge n+1.
- Throughput is one operation per cycle when `rsp_ready` is held high.
- Back-pressure with `rsp_ready`=0:
  - S2 holds its response.
  - S1 fills, then `req_ready` falls combinationally.
  - At most 2 operations are in flight; none is lost or reordered.
- A response handshake and an S1 advance on the same edge replace S2 atomically.
- `flags` updates on the same edge that S2 loads.

## Test plan
- Add A=5, B=3, op=010, setflags=1 → two cycles later `rsp_result`=8, `rsp_flags`=0000, `flags`=0000.
- Subtract:
  - A=3, B=5 → `rsp_result`=0xFFFF_FFFF_FFFF_FFFE, flags N=1, Z=0, V=0, C=0.
  - A=5, B=5 → `rsp_result`=0, Z=1, C=1.
- Add A=0x7FFF_FFFF_FFFF_FFFF, B=1, setflags=0 → `rsp_result`=0x8000_0000_0000_0000, `rsp_flags` N=1, V=1, C=0; `flags` unchanged.
- Hold `rsp_ready`=0 and issue tags 1, 2, 3 back-to-back → only tags 1 and 2 accepted, `req_ready`=0. Then release `rsp_ready` → responses emerge in order 1, 2, 3; `op_count`=3.
- op=111 with setflags=1 → `rsp_err`=1, `rsp_result`=0, `alu_cntrl`=000; `flags` unchanged.
- Two operations in flight:
  - Assert `flush` → `rsp_valid`=0 next cycle and no responses appear.
  - Repeat with `rst_n` asserted mid-cycle → all outputs go to their reset values immediately.
